// File: rtl/salu_decode_table_if.sv
// Lookup request / decode result bundle for salu_decode_table.
// Every field is a packed vector carrying one slot per lookup port.
interface salu_decode_table_if #(
    parameter int NUM_PORTS = 2,
    parameter int OPC_W     = 8,
    parameter int ENTRY_W   = 16,
    parameter int TAG_W     = 6
);
    logic [NUM_PORTS-1:0]         lkp_valid;
    logic [NUM_PORTS*OPC_W-1:0]   lkp_opc;
    logic [NUM_PORTS*TAG_W-1:0]   lkp_tag;
    logic [NUM_PORTS-1:0]         lkp_ready;
    logic [NUM_PORTS-1:0]         res_valid;
    logic [NUM_PORTS*ENTRY_W-1:0] res_entry;
    logic [NUM_PORTS*TAG_W-1:0]   res_tag;
    logic [NUM_PORTS-1:0]         res_illegal;
    logic [NUM_PORTS-1:0]         res_ready;

    // Requester / result consumer side
    modport master (
        output lkp_valid, lkp_opc, lkp_tag, res_ready,
        input  lkp_ready, res_valid, res_entry, res_tag, res_illegal
    );

    // Decode table side
    modport slave (
        input  lkp_valid, lkp_opc, lkp_tag, res_ready,
        output lkp_ready, res_valid, res_entry, res_tag, res_illegal
    );
endinterface

// File: rtl/salu_decode_table.sv
// Programmable SALU opcode decode table with NUM_PORTS independent
// one-register valid/ready lookup channels, same-cycle write bypass and
// a saturating count of illegal (unprogrammed / out-of-range) lookups.
module salu_decode_table #(
    parameter int NUM_ENTRIES = 64,
    parameter int NUM_PORTS   = 2,
    parameter int OPC_W       = 8,
    parameter int ENTRY_W     = 16,
    parameter int TAG_W       = 6
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cfg_we,
    input  logic [OPC_W-1:0]   cfg_addr,
    input  logic [ENTRY_W-1:0] cfg_data,
    input  logic               cfg_clr,
    salu_decode_table_if.slave lkp,
    output logic [15:0]        illegal_cnt
);
    localparam int IDX_W = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;
    localparam logic [OPC_W:0] NUM_ENTRIES_EXT = (OPC_W + 1)'(NUM_ENTRIES);

    logic [ENTRY_W-1:0]           table_q [NUM_ENTRIES];
    logic [ENTRY_W-1:0]           table_d [NUM_ENTRIES];
    logic [NUM_ENTRIES-1:0]       prog_q, prog_d;
    logic                         cfg_hit;
    logic [IDX_W-1:0]             cfg_idx;

    logic [NUM_PORTS-1:0]         res_valid_q, res_valid_d;
    logic [NUM_PORTS-1:0]         res_illegal_q, res_illegal_d;
    logic [NUM_PORTS*ENTRY_W-1:0] res_entry_q, res_entry_d;
    logic [NUM_PORTS*TAG_W-1:0]   res_tag_q, res_tag_d;
    logic [15:0]                  illegal_cnt_q, illegal_cnt_d;
    logic [NUM_PORTS-1:0]         ready;

    logic [OPC_W-1:0]             opc;
    logic [IDX_W-1:0]             idx;
    logic                         in_range, bypass, hit_prog, ill;
    logic [ENTRY_W-1:0]           entry;
    logic [16:0]                  cnt_sum;

    assign ready           = ~res_valid_q | lkp.res_ready;
    assign lkp.lkp_ready   = ready;
    assign lkp.res_valid   = res_valid_q;
    assign lkp.res_illegal = res_illegal_q;
    assign lkp.res_entry   = res_entry_q;
    assign lkp.res_tag     = res_tag_q;
    assign illegal_cnt     = illegal_cnt_q;

    // Table write: in-range addresses store data and mark the entry programmed
    always_comb begin
        table_d = table_q;
        prog_d  = prog_q;
        cfg_hit = cfg_we && ({1'b0, cfg_addr} < NUM_ENTRIES_EXT);
        cfg_idx = cfg_addr[IDX_W-1:0];
        if (cfg_hit) begin
            table_d[cfg_idx] = cfg_data;
            prog_d[cfg_idx]  = 1'b1;
        end
    end

    // Per-port lookup, result register update and illegal counting
    always_comb begin
        res_valid_d   = res_valid_q;
        res_illegal_d = res_illegal_q;
        res_entry_d   = res_entry_q;
        res_tag_d     = res_tag_q;
        opc           = '0;
        idx           = '0;
        in_range      = 1'b0;
        bypass        = 1'b0;
        hit_prog      = 1'b0;
        ill           = 1'b0;
        entry         = '0;
        // Clear takes effect before this cycle's illegal lookups are added
        cnt_sum       = cfg_clr ? '0 : {1'b0, illegal_cnt_q};
        for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            opc      = lkp.lkp_opc[p*OPC_W +: OPC_W];
            idx      = opc[IDX_W-1:0];
            in_range = ({1'b0, opc} < NUM_ENTRIES_EXT);
            // A same-cycle write to this opcode wins over the stored entry
            bypass   = cfg_hit && (cfg_addr == opc);
            hit_prog = in_range && prog_q[idx];
            ill      = !(bypass || hit_prog);
            entry    = bypass ? cfg_data : (hit_prog ? table_q[idx] : '0);
            if (lkp.lkp_valid[p] && ready[p]) begin
                res_valid_d[p]                  = 1'b1;
                res_illegal_d[p]                = ill;
                res_entry_d[p*ENTRY_W +: ENTRY_W] = entry;
                res_tag_d[p*TAG_W +: TAG_W]     = lkp.lkp_tag[p*TAG_W +: TAG_W];
                if (ill) begin
                    cnt_sum = cnt_sum + 17'd1;
                end
            end else if (lkp.res_ready[p]) begin
                res_valid_d[p] = 1'b0;
            end
        end
        illegal_cnt_d = cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
    end

    // Table data storage; unprogrammed contents are masked by prog_q
    always_ff @(posedge clk) begin
        table_q <= table_d;
    end

    // Control state with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prog_q        <= '0;
            res_valid_q   <= '0;
            res_illegal_q <= '0;
            res_entry_q   <= '0;
            res_tag_q     <= '0;
            illegal_cnt_q <= '0;
        end else begin
            prog_q        <= prog_d;
            res_valid_q   <= res_valid_d;
            res_illegal_q <= res_illegal_d;
            res_entry_q   <= res_entry_d;
            res_tag_q     <= res_tag_d;
            illegal_cnt_q <= illegal_cnt_d;
        end
    end
endmodule

// File: tb/tb_salu_decode_table.sv
// Directed bench for salu_decode_table: a table of single-cycle vectors
// followed by hand-written backpressure, saturation and reset sequences.
module tb_salu_decode_table;
    logic        clk;
    logic        rst_n;
    logic        cfg_we;
    logic [7:0]  cfg_addr;
    logic [15:0] cfg_data;
    logic        cfg_clr;
    logic [15:0] illegal_cnt;

    int checks;
    int errors;

    salu_decode_table_if #(.NUM_PORTS(2), .OPC_W(8), .ENTRY_W(16), .TAG_W(6)) bus ();

    salu_decode_table #(
        .NUM_ENTRIES(64),
        .NUM_PORTS(2),
        .OPC_W(8),
        .ENTRY_W(16),
        .TAG_W(6)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cfg_we     (cfg_we),
        .cfg_addr   (cfg_addr),
        .cfg_data   (cfg_data),
        .cfg_clr    (cfg_clr),
        .lkp        (bus),
        .illegal_cnt(illegal_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [7:0]  addr;
        logic [15:0] data;
        logic        clr;
        logic [1:0]  vld;
        logic [7:0]  opc0;
        logic [7:0]  opc1;
        logic [5:0]  tag0;
        logic [5:0]  tag1;
        logic [1:0]  e_vld;
        logic [15:0] e_ent0;
        logic [15:0] e_ent1;
        logic [1:0]  e_ill;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t vecs [11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] vld, input logic [7:0] o0, input logic [7:0] o1,
                         input logic [5:0] t0, input logic [5:0] t1);
        bus.lkp_valid = vld;
        bus.lkp_opc   = {o1, o0};
        bus.lkp_tag   = {t1, t0};
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        cfg_we = 1'b0;
        cfg_addr = '0;
        cfg_data = '0;
        cfg_clr = 1'b0;
        bus.res_ready = 2'b11;
        drive(2'b00, 8'd0, 8'd0, 6'd0, 6'd0);

        //            we    addr    data      clr   vld    opc0    opc1    tag0  tag1  e_vld  e_ent0    e_ent1    e_ill  e_cnt
        vecs[0]  = '{1'b1, 8'd5,  16'h1234, 1'b0, 2'b00, 8'd0,   8'd0,   6'd0, 6'd0, 2'b00, 16'h0000, 16'h0000, 2'b00, 16'd0};
        vecs[1]  = '{1'b0, 8'd0,  16'h0000, 1'b0, 2'b11, 8'd5,   8'd7,   6'd3, 6'd1, 2'b11, 16'h1234, 16'h0000, 2'b10, 16'd1};
        vecs[2]  = '{1'b1, 8'd9,  16'hBEEF, 1'b0, 2'b10, 8'd0,   8'd9,   6'd0, 6'd2, 2'b10, 16'h0000, 16'hBEEF, 2'b00, 16'd1};
        vecs[3]  = '{1'b0, 8'd0,  16'h0000, 1'b0, 2'b11, 8'd200, 8'd200, 6'd4, 6'd5, 2'b11, 16'h0000, 16'h0000, 2'b11, 16'd3};
        vecs[4]  = '{1'b1, 8'd69, 16'hFFFF, 1'b0, 2'b11, 8'd5,   8'd5,   6'd6, 6'd7, 2'b11, 16'h1234, 16'h1234, 2'b00, 16'd3};
        vecs[5]  = '{1'b0, 8'd0,  16'h0000, 1'b0, 2'b11, 8'd63,  8'd64,  6'd8, 6'd9, 2'b11, 16'h0000, 16'h0000, 2'b11, 16'd5};
        vecs[6]  = '{1'b1, 8'd63, 16'h00A5, 1'b0, 2'b11, 8'd63,  8'd9,   6'd10,6'd11,2'b11, 16'h00A5, 16'hBEEF, 2'b00, 16'd5};
        vecs[7]  = '{1'b0, 8'd0,  16'h0000, 1'b1, 2'b11, 8'd255, 8'd63,  6'd12,6'd13,2'b11, 16'h0000, 16'h00A5, 2'b01, 16'd1};
        vecs[8]  = '{1'b0, 8'd0,  16'h0000, 1'b1, 2'b00, 8'd0,   8'd0,   6'd0, 6'd0, 2'b00, 16'h0000, 16'h0000, 2'b00, 16'd0};
        vecs[9]  = '{1'b1, 8'd5,  16'h5678, 1'b0, 2'b11, 8'd5,   8'd5,   6'd14,6'd15,2'b11, 16'h5678, 16'h5678, 2'b00, 16'd0};
        vecs[10] = '{1'b0, 8'd0,  16'h0000, 1'b0, 2'b10, 8'd0,   8'd5,   6'd0, 6'd16,2'b10, 16'h0000, 16'h5678, 2'b00, 16'd0};

        // Reset state
        #12;
        chk("reset_lkp_ready", 32'(bus.lkp_ready), 32'h3);
        chk("reset_res_valid", 32'(bus.res_valid), 32'h0);
        chk("reset_illegal_cnt", 32'(illegal_cnt), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("post_reset_lkp_ready", 32'(bus.lkp_ready), 32'h3);

        // Table-driven single-cycle vectors, consumer always ready
        for (int i = 0; i < 11; i++) begin
            cfg_we   = vecs[i].we;
            cfg_addr = vecs[i].addr;
            cfg_data = vecs[i].data;
            cfg_clr  = vecs[i].clr;
            drive(vecs[i].vld, vecs[i].opc0, vecs[i].opc1, vecs[i].tag0, vecs[i].tag1);
            tick();
            chk($sformatf("v%0d_res_valid", i), 32'(bus.res_valid), 32'(vecs[i].e_vld));
            chk($sformatf("v%0d_illegal_cnt", i), 32'(illegal_cnt), 32'(vecs[i].e_cnt));
            if (vecs[i].e_vld[0]) begin
                chk($sformatf("v%0d_entry0", i), 32'(bus.res_entry[15:0]), 32'(vecs[i].e_ent0));
                chk($sformatf("v%0d_tag0", i), 32'(bus.res_tag[5:0]), 32'(vecs[i].tag0));
                chk($sformatf("v%0d_ill0", i), 32'(bus.res_illegal[0]), 32'(vecs[i].e_ill[0]));
            end
            if (vecs[i].e_vld[1]) begin
                chk($sformatf("v%0d_entry1", i), 32'(bus.res_entry[31:16]), 32'(vecs[i].e_ent1));
                chk($sformatf("v%0d_tag1", i), 32'(bus.res_tag[11:6]), 32'(vecs[i].tag1));
                chk($sformatf("v%0d_ill1", i), 32'(bus.res_illegal[1]), 32'(vecs[i].e_ill[1]));
            end
        end
        cfg_we = 1'b0;
        cfg_clr = 1'b0;

        // Port 0 backpressure for 3 cycles while port 1 streams
        bus.res_ready = 2'b10;
        drive(2'b11, 8'd5, 8'd9, 6'd7, 6'd10);
        tick();
        chk("bp_load_entry0", 32'(bus.res_entry[15:0]), 32'h5678);
        chk("bp_load_tag0", 32'(bus.res_tag[5:0]), 32'd7);
        chk("bp_load_entry1", 32'(bus.res_entry[31:16]), 32'hBEEF);
        for (int i = 0; i < 3; i++) begin
            // Pending illegal request on stalled port must not be counted
            drive(2'b11, 8'd200, 8'd9, 6'd9, 6'(11 + i));
            tick();
            chk($sformatf("bp%0d_lkp_ready0", i), 32'(bus.lkp_ready[0]), 32'h0);
            chk($sformatf("bp%0d_res_valid", i), 32'(bus.res_valid), 32'h3);
            chk($sformatf("bp%0d_entry0", i), 32'(bus.res_entry[15:0]), 32'h5678);
            chk($sformatf("bp%0d_tag0", i), 32'(bus.res_tag[5:0]), 32'd7);
            chk($sformatf("bp%0d_ill0", i), 32'(bus.res_illegal[0]), 32'h0);
            chk($sformatf("bp%0d_entry1", i), 32'(bus.res_entry[31:16]), 32'hBEEF);
            chk($sformatf("bp%0d_tag1", i), 32'(bus.res_tag[11:6]), 32'(11 + i));
            chk($sformatf("bp%0d_illegal_cnt", i), 32'(illegal_cnt), 32'd0);
        end
        drive(2'b01, 8'd9, 8'd0, 6'd8, 6'd0);
        bus.res_ready = 2'b11;
        #1;
        chk("bp_release_lkp_ready", 32'(bus.lkp_ready), 32'h3);
        tick();
        chk("bp_release_valid", 32'(bus.res_valid), 32'h1);
        chk("bp_release_entry0", 32'(bus.res_entry[15:0]), 32'hBEEF);
        chk("bp_release_tag0", 32'(bus.res_tag[5:0]), 32'd8);
        drive(2'b00, 8'd0, 8'd0, 6'd0, 6'd0);
        tick();
        chk("bp_drain_valid", 32'(bus.res_valid), 32'h0);

        // Illegal counter saturation
        cfg_clr = 1'b1;
        tick();
        chk("sat_clear", 32'(illegal_cnt), 32'h0);
        cfg_clr = 1'b0;
        drive(2'b11, 8'd200, 8'd200, 6'd1, 6'd2);
        repeat (32767) tick();
        chk("sat_fffe", 32'(illegal_cnt), 32'hFFFE);
        tick();
        chk("sat_ffff", 32'(illegal_cnt), 32'hFFFF);
        tick();
        chk("sat_hold2", 32'(illegal_cnt), 32'hFFFF);
        drive(2'b01, 8'd200, 8'd0, 6'd1, 6'd0);
        tick();
        chk("sat_hold1", 32'(illegal_cnt), 32'hFFFF);
        drive(2'b00, 8'd0, 8'd0, 6'd0, 6'd0);
        cfg_clr = 1'b1;
        tick();
        chk("sat_clr", 32'(illegal_cnt), 32'h0);
        cfg_clr = 1'b0;

        // Reset while a result is held under backpressure
        bus.res_ready = 2'b10;
        drive(2'b01, 8'd5, 8'd0, 6'd1, 6'd0);
        tick();
        drive(2'b00, 8'd0, 8'd0, 6'd0, 6'd0);
        tick();
        chk("hold_valid", 32'(bus.res_valid[0]), 32'h1);
        chk("hold_entry0", 32'(bus.res_entry[15:0]), 32'h5678);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 32'(bus.res_valid), 32'h0);
        chk("async_rst_entry", 32'(bus.res_entry), 32'h0);
        chk("async_rst_ready", 32'(bus.lkp_ready), 32'h3);
        @(negedge clk);
        rst_n = 1'b1;
        bus.res_ready = 2'b11;
        @(posedge clk);
        #1;
        drive(2'b01, 8'd5, 8'd0, 6'd2, 6'd0);
        tick();
        chk("post_rst_valid", 32'(bus.res_valid), 32'h1);
        chk("post_rst_ill0", 32'(bus.res_illegal[0]), 32'h1);
        chk("post_rst_entry0", 32'(bus.res_entry[15:0]), 32'h0);
        chk("post_rst_tag0", 32'(bus.res_tag[5:0]), 32'd2);
        chk("post_rst_cnt", 32'(illegal_cnt), 32'd1);
        drive(2'b00, 8'd0, 8'd0, 6'd0, 6'd0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
